// File: rtl/dsalu_pkg.sv
// Shared definitions for the digit-serial ALU: op encodings, FSM states, counter sizing.
package dsalu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT  = 3'b101;
  localparam logic [OP_W-1:0] OP_SLTU = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  // Digit counter width; one spare bit so NDIG itself is representable.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return $clog2(ndig) + 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT_W-wide ripple adder; exposes the carry into the MSB for signed-overflow detection.
module digit_adder #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU, LSB digit first, one digit per cycle with a registered result stream.
// Define DIGIT_SERIAL_ALU_OVF_EN to add the flag_v signed-overflow output.
module digit_serial_alu
  import dsalu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIGIT_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [DIGIT_W-1:0] rs1_digit,
  input  logic [DIGIT_W-1:0] rs2_digit,
  output logic               busy,
  output logic               rd_valid,
  output logic [DIGIT_W-1:0] rd_digit,
  output logic               done,
  output logic               flag_c,
  output logic               flag_z,
`ifdef DIGIT_SERIAL_ALU_OVF_EN
  output logic               flag_v,
`endif
  output logic               flag_lt
);

  localparam int unsigned NDIG  = XLEN / DIGIT_W;
  localparam int unsigned CNT_W = cnt_width(NDIG);

  if ((XLEN % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("digit_serial_alu: DIGIT_W must divide XLEN");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              z_acc_q, z_acc_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic               busy_d, rd_valid_d, done_d;
  logic [DIGIT_W-1:0] rd_digit_d;
  logic               flag_c_d, flag_z_d, flag_lt_d;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
  logic               flag_v_d;
`endif

  logic               accept, consume, last, sub_like, ovf;
  logic [OP_W-1:0]    cur_op;
  logic [DIGIT_W-1:0] add_b, add_sum;
  logic               add_cin, add_cout, add_cmsb;

  // On the accept cycle the live op/seed are used since nothing is latched yet.
  assign accept   = (state_q == S_IDLE) && start;
  assign consume  = accept || (state_q == S_RUN);
  assign cur_op   = accept ? op : op_q;
  assign sub_like = (cur_op == OP_SUB) || (cur_op == OP_SLT) || (cur_op == OP_SLTU);
  assign add_b    = sub_like ? ~rs2_digit : rs2_digit;
  assign add_cin  = accept ? sub_like : carry_q;
  assign last     = accept ? (NDIG == 1) : (cnt_q == CNT_W'(NDIG - 1));
  assign ovf      = add_cmsb ^ add_cout;

  digit_adder #(.W(DIGIT_W)) u_adder (
    .a    (rs1_digit),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .cmsb (add_cmsb)
  );

  // Next-state, result digit and flag update.
  always_comb begin
    logic [DIGIT_W-1:0] res;
    logic               z_next;

    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    z_acc_d    = z_acc_q;
    op_d       = op_q;
    busy_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_digit_d = '0;
    done_d     = 1'b0;
    flag_c_d   = flag_c;
    flag_z_d   = flag_z;
    flag_lt_d  = flag_lt;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
    flag_v_d   = flag_v;
`endif

    case (cur_op)
      OP_ADD, OP_SUB: res = add_sum;
      OP_XOR:         res = rs1_digit ^ rs2_digit;
      OP_AND:         res = rs1_digit & rs2_digit;
      OP_OR:          res = rs1_digit | rs2_digit;
      default:        res = '0;
    endcase

    z_next = (accept ? 1'b1 : z_acc_q) & (res == '0);

    if (consume) begin
      state_d    = last ? S_IDLE : S_RUN;
      cnt_d      = last ? '0 : CNT_W'(cnt_q + CNT_W'(1));
      carry_d    = add_cout;
      z_acc_d    = z_next;
      op_d       = cur_op;
      busy_d     = 1'b1;
      rd_valid_d = 1'b1;
      rd_digit_d = res;
      done_d     = last;

      if (accept) begin
        flag_c_d  = 1'b0;
        flag_z_d  = 1'b0;
        flag_lt_d = 1'b0;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
        flag_v_d  = 1'b0;
`endif
      end

      if (last) begin
        flag_c_d  = (cur_op == OP_ADD) || sub_like ? add_cout : 1'b0;
        flag_z_d  = (cur_op == OP_RSVD) ? 1'b0 : z_next;
        flag_lt_d = (cur_op == OP_SLT)  ? (add_sum[DIGIT_W-1] ^ ovf) :
                    (cur_op == OP_SLTU) ? ~add_cout : 1'b0;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
        flag_v_d  = ((cur_op == OP_ADD) || (cur_op == OP_SUB)) ? ovf : 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      z_acc_q  <= 1'b0;
      op_q     <= '0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_digit <= '0;
      done     <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_lt  <= 1'b0;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
      flag_v   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      z_acc_q  <= z_acc_d;
      op_q     <= op_d;
      busy     <= busy_d;
      rd_valid <= rd_valid_d;
      rd_digit <= rd_digit_d;
      done     <= done_d;
      flag_c   <= flag_c_d;
      flag_z   <= flag_z_d;
      flag_lt  <= flag_lt_d;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
      flag_v   <= flag_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu (XLEN=8, DIGIT_W=2): directed cases plus random ops vs. an arithmetic model.
module tb_digit_serial_alu;
  import dsalu_pkg::*;

  localparam int unsigned XLEN = 8;
  localparam int unsigned DW   = 2;
  localparam int unsigned NDIG = XLEN / DW;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [2:0]    op;
  logic [DW-1:0] rs1_digit, rs2_digit;
  logic          busy, rd_valid, done, flag_c, flag_z, flag_lt;
  logic [DW-1:0] rd_digit;
`ifdef DIGIT_SERIAL_ALU_OVF_EN
  logic          flag_v;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic ex_c, ex_z, ex_lt, ex_v;

  digit_serial_alu #(.XLEN(XLEN), .DIGIT_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs1_digit (rs1_digit),
    .rs2_digit (rs2_digit),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_digit  (rd_digit),
    .done      (done),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
`ifdef DIGIT_SERIAL_ALU_OVF_EN
    .flag_v    (flag_v),
`endif
    .flag_lt   (flag_lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result and flags straight from operand values.
  function automatic void model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic c, output logic z,
                                output logic lt, output logic v);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 8'h00; c = 1'b0; z = 1'b0; lt = 1'b0; v = 1'b0;
    case (f)
      OP_ADD: begin
        res = a + b; c = (int'(a) + int'(b)) > 255;
        s = sa + sb; v = (s > 127) || (s < -128); z = (res == 8'h00);
      end
      OP_SUB: begin
        res = a - b; c = (a >= b);
        s = sa - sb; v = (s > 127) || (s < -128); z = (res == 8'h00);
      end
      OP_XOR: begin res = a ^ b; z = (res == 8'h00); end
      OP_AND: begin res = a & b; z = (res == 8'h00); end
      OP_OR:  begin res = a | b; z = (res == 8'h00); end
      OP_SLT:  begin c = (a >= b); lt = (sa < sb); z = 1'b1; end
      OP_SLTU: begin c = (a >= b); lt = (a < b);   z = 1'b1; end
      default: ;
    endcase
  endfunction

  task automatic check_flags(input string tag, input logic c, input logic z, input logic lt, input logic v);
    check({tag, ".flag_c"},  32'(flag_c),  32'(c));
    check({tag, ".flag_z"},  32'(flag_z),  32'(z));
    check({tag, ".flag_lt"}, 32'(flag_lt), 32'(lt));
`ifdef DIGIT_SERIAL_ALU_OVF_EN
    check({tag, ".flag_v"},  32'(flag_v),  32'(v));
`else
    if (v) begin end
`endif
  endtask

  // Streams one operation; called at a negedge, returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input bit hold);
    logic [7:0] r;
    logic c, z, lt, v;
    string tag;
    model(f, a, b, r, c, z, lt, v);
    start = 1'b1; op = f; rs1_digit = a[DW-1:0]; rs2_digit = b[DW-1:0];
    for (int k = 0; k < int'(NDIG); k++) begin
      @(posedge clk); @(negedge clk);
      tag = $sformatf("op%0d a=%02h b=%02h d%0d", f, a, b, k);
      check({tag, " rd_valid"}, 32'(rd_valid), 32'(1));
      check({tag, " rd_digit"}, 32'(rd_digit), 32'(r[k*DW +: DW]));
      check({tag, " busy"},     32'(busy),     32'(1));
      check({tag, " done"},     32'(done),     32'(k == int'(NDIG) - 1));
      if (k == 0) check_flags({tag, " clr"}, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k < int'(NDIG) - 1) begin
        start     = hold;
        op        = 3'($urandom);
        rs1_digit = a[(k+1)*DW +: DW];
        rs2_digit = b[(k+1)*DW +: DW];
      end
    end
    check_flags(tag, c, z, lt, v);
    ex_c = c; ex_z = z; ex_lt = lt; ex_v = v;
  endtask

  task automatic idle(input int n);
    start = 1'b0; op = 3'($urandom);
    rs1_digit = DW'($urandom); rs2_digit = DW'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check("idle rd_valid", 32'(rd_valid), 32'(0));
      check("idle busy",     32'(busy),     32'(0));
      check("idle done",     32'(done),     32'(0));
      check_flags("idle hold", ex_c, ex_z, ex_lt, ex_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs1_digit = '0; rs2_digit = '0;
    ex_c = 1'b0; ex_z = 1'b0; ex_lt = 1'b0; ex_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy",     32'(busy),     32'(0));
    check("reset rd_valid", 32'(rd_valid), 32'(0));
    check("reset rd_digit", 32'(rd_digit), 32'(0));
    check("reset done",     32'(done),     32'(0));
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);

    run_op(OP_ADD, 8'h05, 8'h03, 1'b0);  idle(1);
    run_op(OP_SUB, 8'h10, 8'h01, 1'b0);  idle(1);
    run_op(OP_SUB, 8'h01, 8'h01, 1'b0);  idle(1);
    run_op(OP_SLT, 8'hFF, 8'h01, 1'b0);  idle(1);
    run_op(OP_SLTU, 8'hFF, 8'h01, 1'b0); idle(1);
    run_op(OP_SLT, 8'h7F, 8'h80, 1'b0);  idle(1);
    run_op(OP_RSVD, 8'hA5, 8'h5A, 1'b0); idle(1);

    // Second op starts in the done cycle of the first: no bubble.
    run_op(OP_AND, 8'hF0, 8'h3C, 1'b0);
    run_op(OP_OR,  8'hF0, 8'h3C, 1'b0);
    idle(1);

    // Abort an ADD just before its last digit.
    start = 1'b1; op = OP_ADD; rs1_digit = 2'b01; rs2_digit = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort done",     32'(done),     32'(0));
    check("abort rd_valid", 32'(rd_valid), 32'(0));
    check("abort busy",     32'(busy),     32'(0));
    check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ex_c = 1'b0; ex_z = 1'b0; ex_lt = 1'b0; ex_v = 1'b0;
    idle(1);
    run_op(OP_ADD, 8'hFF, 8'h01, 1'b0); idle(1);

    // start held high through RUN must be ignored.
    run_op(OP_ADD, 8'h7F, 8'h01, 1'b1); idle(1);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_alu.md
Name: digit_serial_alu

Overview:
- Parametrised digit-serial ALU for the bit-serial CPU datapath; generalises the 1-bit serial ALU to DIGIT_W bits per cycle.
- Owns its own operation sequencing: digit counter, start/busy/done handshake, carry chain across digits and end-of-operation flags.
- Operands stream in LSB-digit first from the register-file shifters; result digits stream out to the writeback shifter.

Parameters:
- XLEN, 32, operand width in bits.
- DIGIT_W, 1, bits processed per cycle; must divide XLEN, elaboration error otherwise.
- NDIG, XLEN/DIGIT_W (derived localparam), digits per operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin operation; the start cycle also carries digit 0
- op  in  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 SLT, 110 SLTU, 111 reserved (result 0)
- rs1_digit  in  DIGIT_W  operand A digit
- rs2_digit  in  DIGIT_W  operand B digit
- busy  out  1  operation in progress, more digits expected
- rd_valid  out  1  rd_digit valid this cycle
- rd_digit  out  DIGIT_W  result digit
- done  out  1  one-cycle pulse alongside the last rd_valid
- flag_c  out  1  final carry (ADD/SUB/SLT/SLTU)
- flag_z  out  1  all result digits zero
- flag_lt  out  1  comparison result (SLT signed, SLTU unsigned)

Behaviour:
- Reset: IDLE, cnt=0, carry=0, busy/rd_valid/done=0, rd_digit=0, all flags=0.
- FSM IDLE/RUN. In IDLE, start=1 latches op, consumes digit 0, sets cnt=1, goes to RUN (NDIG=1: stays IDLE, done next cycle).
- RUN consumes one digit per cycle; inputs must be valid every cycle, no stall. At cnt==NDIG-1, it consumes the last digit and returns to IDLE.
- busy=1 from the cycle after start until the cycle after the last digit is consumed.
- Latency 1: digit k sampled at edge E gives rd_digit k and rd_valid=1 after E. done=1 with digit NDIG-1.
- Carry seed on digit 0: 0 for ADD, 1 for SUB/SLT/SLTU. The B operand is inverted for SUB/SLT/SLTU. After each digit, carry becomes that digit's carry-out.
- XOR/AND/OR: bitwise, carry ignored. flag_c=0.
- SLT/SLTU: the difference is computed internally. rd_digit outputs 0 for every digit. flag_lt is updated at done: SLTU lt = ~final carry; SLT lt = N^V, where N is the difference MSB and V=(a_msb^b_msb)&(a_msb^diff_msb).
- flag_z accumulates over the rd_digit values emitted; SLT/SLTU therefore report z=1.
- Flags update on the done cycle and hold until the next accepted start. They are cleared on accept.
- start during RUN is ignored; op and the counter are unaffected.
- Back-to-back: start in the cycle that IDLE is re-entered (the done cycle) is accepted. No bubble.
- Reset mid-operation aborts: no done, flags cleared, next start begins fresh.
- Reserved op: rd_digit=0, flags=0, sequencing normal.

Optional Feature:
- DIGIT_SERIAL_ALU_OVF_EN defined: adds output port flag_v (1 bit). flag_v is signed overflow V for ADD/SUB, updated and held like the other flags, and 0 for other ops. Reset 0.
- Not defined: port and logic absent. V is still computed internally for SLT.

Decomposition:
- Package dsalu_pkg: op encoding localparams (OP_ADD..OP_SLTU), FSM state typedef {S_IDLE, S_RUN}, width helper for cnt ($clog2(NDIG)+1).
- Sub-module digit_adder: DIGIT_W-wide ripple adder. Inputs a, b, cin. Outputs sum, cout, plus MSB-carry-in for the V computation. Instantiated once.

Test Plan:
- XLEN=32, DIGIT_W=1, ADD 0x0000_0005+0x0000_0003 -> rd stream 0x8, done at cycle 32 after start, c=0, z=0.
- XLEN=8, DIGIT_W=2, SUB 0x10-0x01 -> rd 0x0F over 4 digits, c=1. SUB 0x01-0x01 -> 0x00, z=1, c=1.
- XLEN=8, DIGIT_W=4: SLT 0xFF vs 0x01 -> lt=1; SLTU same -> lt=0; SLT 0x7F vs 0x80 -> lt=0, rd all 0.
- Back-to-back: AND 0xF0&0x3C then immediate OR in the done cycle -> 0x30 then 0xFC, no gap in rd_valid, busy continuous.
- rst_n low at digit 3 of an ADD -> no done, flags 0. A following ADD 0xFF+0x01 (XLEN=8) -> 0x00, c=1, z=1; flag_v=0 with OVF_EN.
- start held high during RUN -> ignored; ADD 0x7F+0x01 -> 0x80, flag_v=1 with DIGIT_SERIAL_ALU_OVF_EN.
